multicycle_datapath: RTL

- Parametrised multi-cycle RV-subset core datapath with an integrated FSM controller, register file, immediate generator, ALU and PC logic.
- Executes one instruction per 3–5+ cycles over shared ALU hardware.
- Talks to external instruction and data memories through req/valid handshakes that tolerate any number of wait states.
- Halts on illegal opcodes with a sticky trap flag.

---
 rtl/multicycle_datapath.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_datapath.sv
// Multi-cycle RV-subset datapath: FSM controller, register file, immediate
// generator, shared ALU and PC logic behind req/valid memory handshakes.
module multicycle_datapath #(
  parameter int unsigned     XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}},
  parameter int unsigned     PC_STEP  = 4
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [31:0]     imem_rdata,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_valid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            retire,
  output logic [XLEN-1:0] pc_out,
  output logic            trap
);

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  function automatic logic legal_f(input logic [31:0] ins);
    logic ok;
    ok = 1'b0;
    case (ins[6:0])
      OP_R: begin
        case ({ins[30], ins[14:12]})
          4'b0000, 4'b1000, 4'b0111, 4'b0110, 4'b0100, 4'b0010: ok = 1'b1;
          default: ok = 1'b0;
        endcase
      end
      OP_I:         ok = (ins[14:12] == 3'b000);
      OP_LD, OP_ST: ok = 1'b1;
      OP_BR:        ok = (ins[14:13] == 2'b00);
      default:      ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [XLEN-1:0] alu_f(input logic [3:0] op,
                                            input logic [XLEN-1:0] x,
                                            input logic [XLEN-1:0] y);
    logic [XLEN-1:0] r;
    case (op)
      4'b0000: r = x + y;
      4'b1000: r = x - y;
      4'b0111: r = x & y;
      4'b0110: r = x | y;
      4'b0100: r = x ^ y;
      4'b0010: r = {{(XLEN-1){1'b0}}, ($signed(x) < $signed(y))};
      default: r = x + y;
    endcase
    return r;
  endfunction

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     ir_q, ir_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic [XLEN-1:0] alu_q, alu_d;
  logic [XLEN-1:0] mdr_q, mdr_d;
  logic            retire_q, retire_d;
  logic            trap_q, trap_d;
  logic [XLEN-1:0] rf_q [0:31];

  logic [6:0]      opcode_s;
  logic [2:0]      f3_s;
  logic [4:0]      rd_s, rs1_s, rs2_s;
  logic [XLEN-1:0] rs1_val_s, rs2_val_s;
  logic [XLEN-1:0] imm_i_s, imm_s_s, imm_b_s, imm_sel_s;
  logic [3:0]      alu_op_s;
  logic [XLEN-1:0] op_b_s;
  logic            br_taken_s;
  logic            rf_we_s;
  logic [XLEN-1:0] rf_wdata_s;

  assign opcode_s = ir_q[6:0];
  assign f3_s     = ir_q[14:12];
  assign rd_s     = ir_q[11:7];
  assign rs1_s    = ir_q[19:15];
  assign rs2_s    = ir_q[24:20];

  assign rs1_val_s = (rs1_s == 5'd0) ? {XLEN{1'b0}} : rf_q[rs1_s];
  assign rs2_val_s = (rs2_s == 5'd0) ? {XLEN{1'b0}} : rf_q[rs2_s];

  // B-format keeps the halfword offset; EXEC shifts it into bytes.
  assign imm_i_s = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
  assign imm_s_s = {{(XLEN-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b_s = {{(XLEN-12){ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8]};

  always_comb begin
    case (opcode_s)
      OP_ST:   imm_sel_s = imm_s_s;
      OP_BR:   imm_sel_s = imm_b_s;
      default: imm_sel_s = imm_i_s;
    endcase
  end

  assign alu_op_s   = (opcode_s == OP_R) ? {ir_q[30], f3_s} : 4'b0000;
  assign op_b_s     = (opcode_s == OP_R) ? b_q : imm_q;
  assign br_taken_s = f3_s[0] ? (a_q != b_q) : (a_q == b_q);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    a_d        = a_q;
    b_d        = b_q;
    imm_d      = imm_q;
    alu_d      = alu_q;
    mdr_d      = mdr_q;
    retire_d   = 1'b0;
    trap_d     = trap_q;
    rf_we_s    = 1'b0;
    rf_wdata_s = alu_q;
    case (state_q)
      S_FETCH: begin
        if (imem_valid) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        a_d   = rs1_val_s;
        b_d   = rs2_val_s;
        imm_d = imm_sel_s;
        if (legal_f(ir_q)) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
        end
      end
      S_EXEC: begin
        alu_d = alu_f(alu_op_s, a_q, op_b_s);
        case (opcode_s)
          OP_R, OP_I:   state_d = S_WB;
          OP_LD, OP_ST: state_d = S_MEM;
          OP_BR: begin
            pc_d     = br_taken_s ? (pc_q + (imm_q << 1)) : (pc_q + STEP);
            retire_d = 1'b1;
            state_d  = S_FETCH;
          end
          default: begin
            state_d = S_TRAP;
            trap_d  = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        if (dmem_valid) begin
          if (opcode_s == OP_ST) begin
            pc_d     = pc_q + STEP;
            retire_d = 1'b1;
            state_d  = S_FETCH;
          end else begin
            mdr_d   = dmem_rdata;
            state_d = S_WB;
          end
        end else begin
          state_d = S_MEM;
        end
      end
      S_WB: begin
        rf_we_s    = 1'b1;
        rf_wdata_s = (opcode_s == OP_LD) ? mdr_q : alu_q;
        pc_d       = pc_q + STEP;
        retire_d   = 1'b1;
        state_d    = S_FETCH;
      end
      S_TRAP: begin
        trap_d  = 1'b1;
        state_d = S_TRAP;
      end
      default: begin
        trap_d  = 1'b1;
        state_d = S_TRAP;
      end
    endcase
  end

  // Reset wins over every state, including an outstanding memory access.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= 32'd0;
      a_q      <= {XLEN{1'b0}};
      b_q      <= {XLEN{1'b0}};
      imm_q    <= {XLEN{1'b0}};
      alu_q    <= {XLEN{1'b0}};
      mdr_q    <= {XLEN{1'b0}};
      retire_q <= 1'b0;
      trap_q   <= 1'b0;
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= {XLEN{1'b0}};
      end
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      imm_q    <= imm_d;
      alu_q    <= alu_d;
      mdr_q    <= mdr_d;
      retire_q <= retire_d;
      trap_q   <= trap_d;
      if (rf_we_s && (rd_s != 5'd0)) begin
        rf_q[rd_s] <= rf_wdata_s;
      end
    end
  end

  assign imem_req   = (state_q == S_FETCH) && !reset;
  assign imem_addr  = pc_q;
  assign dmem_req   = (state_q == S_MEM) && !reset;
  assign dmem_we    = (state_q == S_MEM) && (opcode_s == OP_ST);
  assign dmem_addr  = alu_q;
  assign dmem_wdata = b_q;
  assign retire     = retire_q;
  assign pc_out     = pc_q;
  assign trap       = trap_q;

endmodule
